// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end framing 10-bit command/address/data words for a memory
//
// Ports:
//   clk       system / SPI bit clock, rising edge
//   rstn      synchronous active-low reset
//   ss_n      slave select, active-low; high aborts the current frame
//   mosi      serial frame in, MSB first
//   miso      serial read data out, MSB first, 0 when not shifting
//   rx_data   last completed frame: [9:8] command, [7:0] address/data
//   rx_valid  one-cycle strobe marking a freshly completed frame
//   tx_data   read data returned by memory
//   tx_valid  tx_data is valid while high
module spi_slave (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  bit_cnt;
    logic [9:0]  shift_reg;
    logic [7:0]  out_shift;
    logic        rd_addr_seen;
    logic        frame_done;    // frame captured; hold state until ss_n rises
    logic        tx_wait;       // READ_DATA frame done, waiting for memory data
    logic        shifting;      // miso shift in progress

    // Command decode happens on the same edge that samples bit 9, so the
    // payload states only ever see bits 8..0.
    always_comb begin
        next_state = state;
        if (ss_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!mosi)
                        next_state = WRITE;
                    else if (rd_addr_seen)
                        next_state = READ_DATA;
                    else
                        next_state = READ_ADD;
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt      <= 4'd0;
            shift_reg    <= 10'd0;
            out_shift    <= 8'd0;
            rd_addr_seen <= 1'b0;
            frame_done   <= 1'b0;
            tx_wait      <= 1'b0;
            shifting     <= 1'b0;
            rx_data      <= 10'd0;
            rx_valid     <= 1'b0;
            miso         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_n) begin
                // Abort: drop any partial frame and pending read; the read
                // address flag survives so a READ_DATA can follow later.
                bit_cnt    <= 4'd0;
                frame_done <= 1'b0;
                tx_wait    <= 1'b0;
                shifting   <= 1'b0;
                out_shift  <= 8'd0;
                miso       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt    <= 4'd0;
                        frame_done <= 1'b0;
                    end
                    CHK_CMD: begin
                        shift_reg <= {9'd0, mosi};
                        bit_cnt   <= 4'd0;
                    end
                    default: begin
                        if (!frame_done) begin
                            shift_reg <= {shift_reg[8:0], mosi};
                            if (bit_cnt == 4'd8) begin
                                rx_data    <= {shift_reg[8:0], mosi};
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                if (state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                                if (state == READ_DATA) begin
                                    rd_addr_seen <= 1'b0;
                                    tx_wait      <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (tx_wait && tx_valid) begin
                            // Bit 7 goes out straight from the latch edge; the
                            // counter then tracks the 7 bits still to send.
                            miso      <= tx_data[7];
                            out_shift <= {tx_data[6:0], 1'b0};
                            bit_cnt   <= 4'd7;
                            shifting  <= 1'b1;
                            tx_wait   <= 1'b0;
                        end else if (shifting) begin
                            if (bit_cnt != 4'd0) begin
                                miso      <= out_shift[7];
                                out_shift <= {out_shift[6:0], 1'b0};
                                bit_cnt   <= bit_cnt - 4'd1;
                            end else begin
                                miso     <= 1'b0;
                                shifting <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave with a frame-level reference model
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: read-address flag and last delivered frame.
    bit         model_flag = 1'b0;
    logic [9:0] model_rx   = 10'd0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rstn     (rstn),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction: nbits < 10 aborts after that many bits. For frames the
    // model classifies as READ_DATA, memory answers after `delay` extra cycles
    // with `rd`; reset_after > 0 applies reset after that many miso bits.
    task automatic run_txn(input string name, input logic [9:0] f, input int nbits,
                           input int delay, input logic [7:0] rd, input int reset_after);
        logic is_rd;
        ss_n = 1'b0; mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
        tick;
        checks++;
        if (rx_valid !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL %s start: rx_valid=%b miso=%b required 0 0", name, rx_valid, miso);
        end
        for (int k = 0; k < nbits; k++) begin
            mosi = f[9-k]; tx_valid = 1'($urandom); tx_data = 8'($urandom);
            tick;
            if (k < 9) begin
                checks++;
                if (rx_valid !== 1'b0 || miso !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bit%0d: rx_valid=%b miso=%b required 0 0", name, 9-k, rx_valid, miso);
                end
            end
        end
        if (nbits < 10) begin
            ss_n = 1'b1; mosi = f[9-nbits];
            tick;
            checks++;
            if (rx_valid !== 1'b0 || rx_data !== model_rx || miso !== 1'b0) begin
                errors++;
                $display("FAIL %s abort: rx_valid=%b rx_data=%h miso=%b required 0 %h 0", name, rx_valid, rx_data, miso, model_rx);
            end
            tick;
            checks++;
            if (rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s post_abort: rx_valid=%b required 0", name, rx_valid);
            end
            return;
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== f) begin
            errors++;
            $display("FAIL %s frame: rx_valid=%b rx_data=%h required 1 %h", name, rx_valid, rx_data, f);
        end
        model_rx = f;
        is_rd = f[9] && model_flag;
        if (f[9]) model_flag = !model_flag;
        tx_valid = 1'b0;
        tick;
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== f || miso !== 1'b0) begin
            errors++;
            $display("FAIL %s hold: rx_valid=%b rx_data=%h miso=%b required 0 %h 0", name, rx_valid, rx_data, miso, f);
        end
        if (is_rd) begin
            for (int d = 0; d < delay; d++) begin
                tx_valid = 1'b0;
                tick;
                checks++;
                if (miso !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait: miso=%b required 0", name, miso);
                end
            end
            tx_valid = 1'b1; tx_data = rd;
            tick;
            checks++;
            if (miso !== rd[7]) begin
                errors++;
                $display("FAIL %s miso7: got %b required %b", name, miso, rd[7]);
            end
            for (int k = 6; k >= 0; k--) begin
                if (reset_after > 0 && (7 - k) == reset_after) begin
                    rstn = 1'b0; ss_n = 1'b0;
                    tick;
                    checks++;
                    if (miso !== 1'b0 || rx_data !== 10'd0 || rx_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s reset: miso=%b rx_data=%h rx_valid=%b required 0 000 0", name, miso, rx_data, rx_valid);
                    end
                    model_flag = 1'b0; model_rx = 10'd0;
                    rstn = 1'b1; ss_n = 1'b1;
                    tick;
                    return;
                end
                tx_valid = 1'($urandom); tx_data = 8'($urandom);
                tick;
                checks++;
                if (miso !== rd[k]) begin
                    errors++;
                    $display("FAIL %s miso%0d: got %b required %b", name, k, miso, rd[k]);
                end
            end
            for (int d = 0; d < 3; d++) begin
                tx_valid = 1'b1; tx_data = 8'($urandom);
                tick;
                checks++;
                if (miso !== 1'b0 || rx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s after_shift: miso=%b rx_valid=%b required 0 0", name, miso, rx_valid);
                end
            end
        end else begin
            for (int d = 0; d < delay + 9; d++) begin
                tx_valid = 1'($urandom); tx_data = 8'($urandom);
                tick;
                checks++;
                if (miso !== 1'b0 || rx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s no_read: miso=%b rx_valid=%b required 0 0", name, miso, rx_valid);
                end
            end
        end
        ss_n = 1'b1; tx_valid = 1'b0;
        tick;
        checks++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== model_rx) begin
            errors++;
            $display("FAIL %s end: miso=%b rx_valid=%b rx_data=%h required 0 0 %h", name, miso, rx_valid, rx_data, model_rx);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; ss_n = 1'b0; mosi = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        tick;
        tick;
        checks++;
        if (rx_data !== 10'd0 || rx_valid !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rx_data=%h rx_valid=%b miso=%b required 000 0 0", rx_data, rx_valid, miso);
        end
        rstn = 1'b1; ss_n = 1'b1; tx_valid = 1'b0;
        tick;
        model_flag = 1'b0; model_rx = 10'd0;
    endtask

    task automatic test_write;
        run_txn("write_addr", 10'h005, 10, 0, 8'h00, 0);
        run_txn("write_data", 10'h1AA, 10, 0, 8'h00, 0);
    endtask

    task automatic test_read;
        run_txn("read_addr", 10'h205, 10, 0, 8'h00, 0);
        run_txn("read_data", 10'h3C3, 10, 0, 8'hA5, 0);
        run_txn("read_addr2", 10'h211, 10, 0, 8'h00, 0);
        run_txn("write_between", 10'h0AA, 10, 2, 8'h00, 0);
        run_txn("read_data_delay", 10'h300, 10, 5, 8'h3C, 0);
    endtask

    task automatic test_abort;
        run_txn("abort5", 10'h3FF, 5, 0, 8'h00, 0);
        run_txn("after_abort", 10'h0F0, 10, 0, 8'h00, 0);
        run_txn("abort_readaddr", 10'h2FF, 9, 0, 8'h00, 0);
        run_txn("read_after_abort", 10'h277, 10, 0, 8'h00, 0);
        run_txn("abort_last_bit", 10'h3FF, 9, 0, 8'h00, 0);
        run_txn("read_data_kept", 10'h312, 10, 1, 8'h96, 0);
    endtask

    task automatic test_reset_mid_shift;
        run_txn("rst_setup", 10'h2AB, 10, 0, 8'h00, 0);
        run_txn("rst_shift", 10'h3CD, 10, 0, 8'hE7, 3);
        run_txn("rst_fresh", 10'h3EE, 10, 0, 8'h00, 0);
    endtask

    task automatic test_idle_spurious;
        ss_n = 1'b1;
        for (int d = 0; d < 5; d++) begin
            tx_valid = 1'b1; tx_data = 8'($urandom); mosi = 1'($urandom);
            tick;
            checks++;
            if (miso !== 1'b0 || rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_spurious: miso=%b rx_valid=%b required 0 0", miso, rx_valid);
            end
        end
        tx_valid = 1'b0;
        run_txn("idle_then_write", 10'h155, 10, 0, 8'h00, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            int nb;
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
            run_txn("random", 10'($urandom), nb, int'($urandom_range(0, 4)), 8'($urandom), 0);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_reset_mid_shift;
        test_idle_spurious;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 clk  input  1  system/SPI bit clock; all logic on rising edge.
REQ-002 rstn  input  1  synchronous, active-low reset.
REQ-003 ss_n  input  1  slave select, active-low; high = bus idle/abort.
REQ-004 mosi  input  1  serial data in, MSB first, one bit per clk.
REQ-005 miso  output  1  serial read data out, MSB first.
REQ-006 rx_data  output  10  assembled frame to memory: [9:8] command, [7:0] address/data.
REQ-007 rx_valid  output  1  one-cycle strobe; rx_data is valid while high.
REQ-008 tx_data  input  8  read data returned by memory.
REQ-009 tx_valid  input  1  tx_data is valid while high.

Function
REQ-010 States SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; state register plus 4-bit bit counter, 10-bit shift register, 8-bit output shifter, 1-bit rd_addr_seen flag.
REQ-011 IDLE -> CHK_CMD on a cycle with ss_n=0; otherwise stay in IDLE.
REQ-012 In CHK_CMD, mosi SHALL be captured as rx_data bit 9; mosi=0 -> WRITE; mosi=1 and rd_addr_seen=0 -> READ_ADD; mosi=1 and rd_addr_seen=1 -> READ_DATA.
REQ-013 In WRITE/READ_ADD/READ_DATA, the next 9 cycles SHALL capture bits 8..0, MSB first.
REQ-014 The cycle after bit 0 is sampled, rx_data SHALL hold the 10 captured bits and rx_valid SHALL be 1 for exactly one cycle.
REQ-015 rx_data SHALL hold its value between frames; rx_valid=0 at all other times.
REQ-016 A completed READ_ADD frame SHALL set rd_addr_seen; a completed READ_DATA frame SHALL clear it; WRITE frames leave it unchanged.
REQ-017 After a READ_DATA rx_valid, the block SHALL wait for tx_valid=1; on the first cycle tx_valid is sampled high it SHALL latch tx_data.
REQ-018 The 8 cycles following the latch cycle SHALL drive miso = tx_data[7], [6], ... [0]; miso=0 in every other cycle.
REQ-019 tx_valid asserted outside a READ_DATA wait SHALL be ignored.
REQ-020 After frame completion (and after the miso shift, for READ_DATA), the block SHALL remain in its state with no further rx_valid until ss_n=1.
REQ-021 ss_n=1 sampled in any non-IDLE state SHALL force IDLE next cycle: bit counter cleared, partial frame discarded, no rx_valid, miso shift aborted to 0, rd_addr_seen unchanged.
REQ-022 Total latency: ss_n low at cycle 0 -> CHK_CMD at cycle 1 -> bits at cycles 1..10 -> rx_valid at cycle 11.
REQ-023 ss_n=1 on the same cycle bit 0 is sampled SHALL discard the frame (no rx_valid).

Reset
REQ-024 rstn=0 at a rising edge SHALL force state IDLE, rx_data=0, rx_valid=0, miso=0, bit counter=0, output shifter=0, rd_addr_seen=0, taking priority over all other inputs.
REQ-025 Reset mid-frame or mid-shift SHALL abort with no rx_valid; the first frame after reset SHALL be treated as a fresh frame in IDLE.

Verification
REQ-026 Write address: ss_n low, mosi 00_0000_0101 -> rx_data=0x005, rx_valid high one cycle at cycle 11, miso stays 0.
REQ-027 Write data: mosi 01_1010_1010 -> rx_data=0x1AA, one rx_valid pulse; rd_addr_seen unchanged.
REQ-028 Read sequence: frame 10_0000_0101 (READ_ADD, rx_data=0x205, flag set), ss_n high, then frame 11_xxxx_xxxx (READ_DATA); memory returns tx_valid with tx_data=0xA5 at cycle 12 -> miso 1,0,1,0,0,1,0,1 on cycles 13..20, then flag cleared.
REQ-029 Abort: ss_n raised after 5 bits -> no rx_valid, IDLE next cycle; following full frame 00_1111_0000 -> rx_data=0x0F0 correctly.
REQ-030 Reset mid-READ_DATA shift (after 3 miso bits) -> miso=0 next cycle, rd_addr_seen=0, next mosi=1 frame decodes as READ_ADD.
REQ-031 Spurious tx_valid=1 in IDLE or WRITE -> miso stays 0, no state change.
